txuart_arbiter: RTL and testbench

- Shares one txuart transmitter between NUM_REQ independent message sources, such as the hello-world sequencer, status reporters and debug dumps.
- Arbitration is round-robin and packet-locked: a granted requester owns the UART until it hands over a byte flagged last.
- A timeout prevents a stalled owner from starving the others.
- Sits between the message generators and the single txuart instance at top level.

---
 rtl/txuart_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/txuart_arbiter.sv | 126 ++++++++++++
 tb/tb_txuart_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txuart_pkg.sv
// Constants shared by txuart, the message generators and the transmit arbiter.
package txuart_pkg;

  localparam int unsigned BYTE_W = 8;

  // 100 MHz system clock divided down to 115200 baud
  localparam int unsigned DEFAULT_BAUD_DIV = 868;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request strictly after last_idx, wrapping at NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LGNUM   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LGNUM-1:0]   last_idx,
  output logic [LGNUM-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [LGNUM-1:0] cand;

  // Offset 1 first so the previous owner is considered last.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = LGNUM'((32'(last_idx) + i) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/txuart_arbiter.sv
// Packet-locked round-robin arbiter sharing one txuart between NUM_REQ message sources,
// with an idle timeout that forcibly releases a stalled owner.
module txuart_arbiter
  import txuart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LGNUM   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_stb,
  input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_busy,
  output logic                      o_tx_stb,
  output logic [BYTE_W-1:0]         o_tx_data,
  input  logic                      i_tx_busy,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [LGNUM-1:0]   gnt_idx_q, gnt_idx_d;
  logic [LGNUM-1:0]   last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [LGNUM-1:0]   pick_idx;
  logic               pick_valid;
  logic               owner_stb;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_data;
  logic               xfer;
  logic               timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .LGNUM   (LGNUM)
  ) u_rr_pick (
    .req        (i_req_stb),
    .last_idx   (last_idx_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign owner_stb  = i_req_stb[gnt_idx_q];
  assign owner_last = i_req_last[gnt_idx_q];
  assign owner_data = i_req_data[BYTE_W * 32'(gnt_idx_q) +: BYTE_W];

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_idx_d  = last_idx_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    o_tx_stb    = 1'b0;
    o_tx_data   = '0;
    o_req_busy  = '1;
    xfer        = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d   = ST_OWN;
          gnt_idx_d = pick_idx;
          grant_d   = NUM_REQ'(1) << pick_idx;
        end
      end

      ST_OWN: begin
        o_tx_stb              = owner_stb;
        o_tx_data             = owner_data;
        o_req_busy[gnt_idx_q] = i_tx_busy;
        xfer                  = owner_stb && !i_tx_busy;

        // Only an absent owner strobe counts as idle; txuart backpressure does not.
        if (owner_stb) begin
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        timeout_hit = (TIMEOUT != 0) && !owner_stb && (cnt_q == CNT_LAST);

        if ((xfer && owner_last) || timeout_hit) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          last_idx_d = gnt_idx_q;
          cnt_d      = '0;
          timeout_d  = timeout_hit;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= LGNUM'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_txuart_arbiter.sv
// Bench for txuart_arbiter: directed scenarios plus random traffic, every cycle checked
// against a message-level model of ownership, round-robin order and idle timeout.
module tb_txuart_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] i_req_stb = '0;
  logic [8*NREQ-1:0] i_req_data = '0;
  logic [NREQ-1:0] i_req_last = '0;
  logic [NREQ-1:0] o_req_busy;
  logic            o_tx_stb;
  logic [7:0]      o_tx_data;
  logic            i_tx_busy = 1'b0;
  logic [NREQ-1:0] o_grant;
  logic            o_timeout;

  txuart_arbiter #(
    .NUM_REQ (NREQ),
    .LGNUM   (2),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req_stb  (i_req_stb),
    .i_req_data (i_req_data),
    .i_req_last (i_req_last),
    .o_req_busy (o_req_busy),
    .o_tx_stb   (o_tx_stb),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .o_grant    (o_grant),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester and txuart environment
  ent_t       q[NREQ][$];
  int         hold[NREQ];
  int         tx_cnt = 0;
  int         busy_len = 3;  // negative: random 0..3 per byte
  logic [7:0] sent_log[NREQ][$];
  logic [7:0] recv_log[NREQ][$];
  logic [7:0] uart_log[$];
  int         gnt_log[$];
  int         to_count = 0;
  int         to_gap = 0;
  int         cyc_n = 0;
  int         last_xfer_cyc = 0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [7:0] exp_q[$];
  int         exp_g[$];

  // Reference model: who owns the UART, who owned it last, how long the owner has been quiet
  int   m_owner;
  int   m_last;
  int   m_quiet;
  logic m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_quiet = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    logic done;
    int   k;
    if (m_owner < 0) begin
      m_to = 1'b0;
      done = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
        k = (m_last + i) % NREQ;
        if (!done && i_req_stb[k]) begin
          done    = 1'b1;
          m_owner = k;
          m_quiet = 0;
        end
      end
    end else begin
      m_to = 1'b0;
      if (i_req_stb[m_owner]) begin
        m_quiet = 0;
        if (!i_tx_busy && i_req_last[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else begin
        m_quiet++;
        if (m_quiet >= TMO) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
        end
      end
    end
  endtask

  task automatic env_clear();
    for (int k = 0; k < NREQ; k++) begin
      q[k].delete();
      sent_log[k].delete();
      recv_log[k].delete();
      hold[k] = 0;
    end
    uart_log.delete();
    gnt_log.delete();
    to_count = 0;
    tx_cnt   = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (q[k].size() > 0 && hold[k] == 0) begin
        i_req_stb[k]          = 1'b1;
        i_req_data[8*k +: 8]  = q[k][0].data;
        i_req_last[k]         = q[k][0].last;
      end else begin
        i_req_stb[k]          = 1'b0;
        i_req_data[8*k +: 8]  = 8'($urandom);
        i_req_last[k]         = 1'($urandom);
      end
    end
    i_tx_busy = (tx_cnt > 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input logic l, input int gap);
    ent_t e;
    e.data = d;
    e.last = l;
    e.gap  = 8'(gap);
    q[k].push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    env_clear();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic chk_uart(input string name);
    chk({name, "_len"}, 32'(uart_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < uart_log.size()) chk(name, 32'(uart_log[i]), 32'(exp_q[i]));
  endtask

  task automatic chk_gnt(input string name);
    chk({name, "_len"}, 32'(gnt_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++)
      if (i < gnt_log.size()) chk(name, 32'(gnt_log[i]), 32'(exp_g[i]));
  endtask

  // Per-cycle comparison against the model, then environment and model advance
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] eb;
    logic            es;
    logic [7:0]      ed;
    cyc_n++;
    eg = '0;
    eb = '1;
    es = 1'b0;
    ed = 8'h00;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eb[m_owner] = i_tx_busy;
      es          = i_req_stb[m_owner];
      ed          = i_req_data[8*m_owner +: 8];
    end
    chk("grant", 32'(o_grant), 32'(eg));
    chk("req_busy", 32'(o_req_busy), 32'(eb));
    chk("tx_stb", 32'(o_tx_stb), 32'(es));
    chk("tx_data", 32'(o_tx_data), 32'(ed));
    chk("timeout", 32'(o_timeout), 32'(m_to));

    if (o_grant != '0 && prev_grant == '0) gnt_log.push_back(onehot_idx(o_grant));
    prev_grant = o_grant;
    if (o_timeout) begin
      to_count++;
      to_gap = cyc_n - last_xfer_cyc;
    end

    if (o_tx_stb && !i_tx_busy) begin
      uart_log.push_back(o_tx_data);
      recv_log[onehot_idx(o_grant)].push_back(o_tx_data);
      last_xfer_cyc = cyc_n;
      tx_cnt = (busy_len < 0) ? int'($urandom_range(3, 0)) : busy_len;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
    end

    for (int k = 0; k < NREQ; k++) begin
      if (i_req_stb[k] && !o_req_busy[k] && q[k].size() > 0) begin
        sent_log[k].push_back(q[k][0].data);
        hold[k] = int'(q[k][0].gap);
        void'(q[k].pop_front());
      end else if (!i_req_stb[k] && hold[k] > 0) begin
        hold[k]--;
      end
    end

    if (!rst) model_step();
  end

  function automatic logic all_empty();
    logic r = 1'b1;
    for (int k = 0; k < NREQ; k++) if (q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  initial begin
    int g;
    model_reset();
    env_clear();
    cyc(2);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_busy", 32'(o_req_busy), 32'hF);
    chk("rst_tx_stb", 32'(o_tx_stb), 32'h0);
    chk("rst_tx_data", 32'(o_tx_data), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);
    rst = 1'b0;

    // "Hi\n" from requester 0
    busy_len = 3;
    push_byte(0, 8'h48, 1'b0, 0);
    push_byte(0, 8'h69, 1'b0, 0);
    push_byte(0, 8'h0A, 1'b1, 0);
    cyc(30);
    exp_q = '{8'h48, 8'h69, 8'h0A};
    chk_uart("hi_bytes");
    exp_g = '{0};
    chk_gnt("hi_grant");
    chk("hi_idle_after", 32'(o_grant), 32'h0);

    // Everyone requesting: strict rotation, messages kept whole
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      push_byte(k, 8'(16 * k + 1), 1'b0, 0);
      push_byte(k, 8'(16 * k + 2), 1'b1, 0);
    end
    push_byte(0, 8'h05, 1'b0, 0);
    push_byte(0, 8'h06, 1'b1, 0);
    cyc(70);
    exp_g = '{0, 1, 2, 3, 0};
    chk_gnt("rr_order");
    exp_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h05, 8'h06};
    chk_uart("rr_bytes");

    // Stalled owner 2 is forced off after TMO quiet cycles
    do_reset();
    push_byte(2, 8'hA0, 1'b0, 40);
    push_byte(2, 8'hA1, 1'b1, 0);
    cyc(3);
    push_byte(3, 8'hB0, 1'b1, 0);
    cyc(90);
    chk("to_count", 32'(to_count), 32'd1);
    chk("to_gap", 32'(to_gap), 32'(TMO + 1));
    exp_g = '{2, 3, 2};
    chk_gnt("to_order");
    exp_q = '{8'hA0, 8'hB0, 8'hA1};
    chk_uart("to_bytes");

    // Released owner 1 re-requests alongside requester 0: 0 goes first
    do_reset();
    busy_len = 0;
    push_byte(1, 8'h11, 1'b1, 0);
    push_byte(1, 8'h12, 1'b1, 0);
    cyc(2);
    push_byte(0, 8'h01, 1'b1, 0);
    cyc(20);
    exp_g = '{1, 0, 1};
    chk_gnt("tie_order");

    // Asynchronous reset mid-message
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(2, 8'(8'hC0 + i), (i == 7), 0);
    cyc(4);
    #1;
    chk("mid_pre_stb", 32'(o_tx_stb), 32'h1);
    rst = 1'b1;
    model_reset();
    env_clear();
    #1;
    chk("mid_rst_stb", 32'(o_tx_stb), 32'h0);
    chk("mid_rst_grant", 32'(o_grant), 32'h0);
    cyc(2);
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) push_byte(k, 8'(8'hE0 + k), 1'b1, 0);
    cyc(30);
    exp_g = '{0, 1, 2, 3};
    chk_gnt("mid_after_order");

    // Non-owner 3 waits through a 5-byte message from 1
    do_reset();
    busy_len = 3;
    for (int i = 0; i < 5; i++) push_byte(1, 8'(8'h51 + i), (i == 4), 0);
    cyc(2);
    push_byte(3, 8'h3A, 1'b0, 0);
    push_byte(3, 8'h3B, 1'b1, 0);
    cyc(60);
    exp_g = '{1, 3};
    chk_gnt("hold_order");
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h3A, 8'h3B};
    chk_uart("hold_bytes");

    // Random traffic, including stalls around the timeout boundary
    do_reset();
    busy_len = -1;
    for (int n = 0; n < 3000; n++) begin
      cyc(1);
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(99, 0) < 4 && q[k].size() < 6) begin
          int len = int'($urandom_range(4, 1));
          for (int i = 0; i < len; i++) begin
            if (i == len - 1) begin
              g = int'($urandom_range(6, 0));
            end else if ($urandom_range(39, 0) == 0) begin
              case ($urandom_range(4, 0))
                0: g = TMO - 2;
                1: g = TMO - 1;
                2: g = TMO;
                3: g = TMO + 1;
                default: g = TMO + 8;
              endcase
            end else begin
              g = int'($urandom_range(2, 0));
            end
            push_byte(k, 8'($urandom), (i == len - 1), g);
          end
        end
      end
    end
    for (int i = 0; i < 3000 && !all_empty(); i++) cyc(1);
    chk("drain_done", 32'(all_empty()), 32'h1);
    cyc(10);
    for (int k = 0; k < NREQ; k++) begin
      chk("rand_count", 32'(recv_log[k].size()), 32'(sent_log[k].size()));
      for (int i = 0; i < sent_log[k].size(); i++)
        if (i < recv_log[k].size()) chk("rand_byte", 32'(recv_log[k][i]), 32'(sent_log[k][i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
